// File: rtl/adder_serial_pkg.sv
// adder_serial shared types: FSM encoding, default geometry
// and the full-adder cell used by the chunk adder.
package adder_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  // returns {carry, sum}
  function automatic logic [1:0] fa(
    input logic x,
    input logic y,
    input logic c
  );
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/adder_serial_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple-carry adder
// with carry-out and carry-into-MSB for overflow detection.
module adder_chunk
  import adder_serial_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign {c[i+1], s[i]} = fa(a[i], b[i], c[i]);
  end

  assign co = c[CHUNK];
  assign cm = c[CHUNK-1];

endmodule

// File: rtl/adder_serial.sv
// adder_serial: multi-cycle adder, CHUNK bits per clock.
// Define ADDER_SUB_EN to add the sub port (a - b).
module adder_serial
  import adder_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           state;
  state_t           nstate;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] as;
  logic [WIDTH-1:0] bs;
  logic             cr;
  logic [WIDTH-1:0] bin;
  logic             cin;
  logic [CHUNK-1:0] cs;
  logic             cc;
  logic             cm;
  logic             last;
  logic             accept;

`ifdef ADDER_SUB_EN
  // two's complement: a + ~b + 1
  assign bin = sub ? ~b : b;
  assign cin = sub | ci;
`else
  assign bin = b;
  assign cin = ci;
`endif

  assign last   = (k == KW'(NCH - 1));
  assign accept = (state == IDLE) && start;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (as[CHUNK-1:0]),
    .b  (bs[CHUNK-1:0]),
    .ci (cr),
    .s  (cs),
    .co (cc),
    .cm (cm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      as  <= '0;
      bs  <= '0;
      cr  <= 1'b0;
      k   <= '0;
      sum <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      as  <= a;
      bs  <= bin;
      cr  <= cin;
      k   <= '0;
      sum <= '0;
    end else if (state == RUN) begin
      // operands shift down so the chunk adder always sees bit 0
      as  <= as >> CHUNK;
      bs  <= bs >> CHUNK;
      cr  <= cc;
      k   <= k + 1'b1;
      sum[int'(k)*CHUNK +: CHUNK] <= cs;
      if (last) begin
        co  <= cc;
        ovf <= cc ^ cm;
      end
    end
  end

endmodule

// File: tb/tb_adder_serial.sv
// tb_adder_serial: random and directed checks of adder_serial
// against an arithmetic reference model.
module tb_adder_serial;

  localparam int NCH0 = 8;
`ifdef ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] b0 = '0;
  logic        ci0 = 1'b0;
  logic        sub0 = 1'b0;
  logic        busy0, done0, co0, ovf0;
  logic [31:0] sum0;

  logic        start1 = 1'b0;
  logic [7:0]  a1 = '0;
  logic [7:0]  b1 = '0;
  logic        ci1 = 1'b0;
  logic        sub1 = 1'b0;
  logic        busy1, done1, co1, ovf1;
  logic [7:0]  sum1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_serial u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (start0),
    .a     (a0),
    .b     (b0),
    .ci    (ci0),
`ifdef ADDER_SUB_EN
    .sub   (sub0),
`endif
    .busy  (busy0),
    .done  (done0),
    .sum   (sum0),
    .co    (co0),
    .ovf   (ovf0)
  );

  adder_serial #(
    .WIDTH (8),
    .CHUNK (8)
  ) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .ci    (ci1),
`ifdef ADDER_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .co    (co1),
    .ovf   (ovf1)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns {ovf, co, sum[31:0]} for a w-bit add/subtract
  function automatic logic [33:0] ref_add(
    input int          w,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        c,
    input logic        s
  );
    longint unsigned m, ux, uy, t, r;
    logic sx, sy, sr, cout, v;
    m  = (64'd1 << w) - 1;
    ux = longint'(x) & m;
    uy = (s ? ~longint'(y) : longint'(y)) & m;
    t  = ux + uy + ((s | c) ? 64'd1 : 64'd0);
    r  = t & m;
    cout = t[w];
    sx = ux[w-1];
    sy = uy[w-1];
    sr = r[w-1];
    v  = (sx == sy) && (sr != sx);
    return {v, cout, r[31:0]};
  endfunction

  task automatic op32(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        c,
    input logic        s,
    input int          inj,
    input int          rcyc
  );
    logic [33:0] e;
    int lat, dc, bc;
    e = ref_add(32, x, y, c, s);
    lat = 0;
    dc  = 0;
    bc  = 0;
    @(negedge clk);
    a0 = x;
    b0 = y;
    ci0 = c;
    sub0 = s;
    start0 = 1'b1;
    for (int i = 1; i <= NCH0 + 6; i++) begin
      @(negedge clk);
      if (done0) begin
        dc++;
        if (lat == 0) lat = i;
      end
      if (busy0) bc++;
      if (rcyc > 0 && i == rcyc + 1) begin
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_sum", 64'(sum0), 64'd0);
        check("rst_co", 64'(co0), 64'd0);
      end
      start0 = 1'b0;
      rst = 1'b0;
      if (i == inj) begin
        start0 = 1'b1;
        a0 = 32'h10;
        b0 = 32'h10;
      end
      if (i == rcyc) rst = 1'b1;
    end
    start0 = 1'b0;
    rst = 1'b0;
    if (rcyc > 0) begin
      check("rst_nodone", 64'(dc), 64'd0);
    end else begin
      check("latency", 64'(lat), 64'(NCH0 + 1));
      check("done_cnt", 64'(dc), 64'd1);
      check("busy_cnt", 64'(bc), 64'(NCH0));
      check("sum", 64'(sum0), 64'(e[31:0]));
      check("co", 64'(co0), 64'(e[32]));
      check("ovf", 64'(ovf0), 64'(e[33]));
    end
  endtask

  task automatic op8(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       c,
    input logic       s
  );
    logic [33:0] e;
    int lat, dc;
    e = ref_add(8, 32'(x), 32'(y), c, s);
    lat = 0;
    dc  = 0;
    @(negedge clk);
    a1 = x;
    b1 = y;
    ci1 = c;
    sub1 = s;
    start1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) begin
        dc++;
        if (lat == 0) lat = i;
      end
    end
    check("w8_latency", 64'(lat), 64'd2);
    check("w8_done_cnt", 64'(dc), 64'd1);
    check("w8_sum", 64'(sum1), 64'(e[7:0]));
    check("w8_co", 64'(co1), 64'(e[32]));
    check("w8_ovf", 64'(ovf1), 64'(e[33]));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done0", 64'(done0), 64'd0);
    check("rst_sum0", 64'(sum0), 64'd0);
    check("rst_co0", 64'(co0), 64'd0);
    check("rst_ovf0", 64'(ovf0), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    rst = 1'b0;

    op32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 0);
    op32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 0);
    op32(32'h1, 32'h2, 1'b0, 1'b0, 3, 0);
    op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 0, 4);
    op32(32'h3, 32'h4, 1'b1, 1'b0, 0, 0);
    if (HAS_SUB) begin
      op32(32'h5, 32'h7, 1'b0, 1'b1, 0, 0);
      op32(32'h7, 32'h5, 1'b0, 1'b1, 0, 0);
    end
    for (int n = 0; n < 20; n++) begin
      op32($urandom, $urandom, 1'($urandom), HAS_SUB & 1'($urandom), 0, 0);
    end

    op8(8'h80, 8'h80, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), HAS_SUB & 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adder_serial.md
# adder_serial

Parametrised multi-cycle adder (subtractor optional) that adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register. It is the sequential successor of the team's single-bit full-adder cell: the same ripple-carry arithmetic, widened and time-multiplexed so a wide add costs one narrow chunk adder plus a start/done handshake. It sits in the datapath wherever area matters more than single-cycle latency.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per RUN cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- a  in  WIDTH  operand A, sampled on accepted start.
- b  in  WIDTH  operand B, sampled on accepted start.
- ci  in  1  carry-in, sampled on accepted start.
- sub  in  1  subtract select; present only with ADDER_SUB_EN.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result; held until the next accepted start.
- co  out  1  carry out of the MSB.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- NCH = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b (into a shift register), ci into carry reg; clear sum; chunk index k=0; go to RUN.
- RUN: add chunk k (bits k·CHUNK+CHUNK-1 : k·CHUNK) with carry reg; write chunk result into sum bits k; update carry reg; k++. After chunk NCH-1: load co, compute ovf, go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- start in RUN or DONE is ignored; no queueing.
- sum/co/ovf change only during RUN (sum cleared on accept); stable from DONE until the next accepted start.
- Arithmetic modulo 2^WIDTH; co is the true carry of a + b + ci.

## Timing
- Reset values: busy=0, done=0, sum=0, co=0, ovf=0, state IDLE, k=0, carry reg=0.
- start accepted at edge 0 → busy high cycles 1..NCH → done high cycle NCH+1 → IDLE in cycle NCH+2; a new start is accepted at the earliest in cycle NCH+2.
- Total latency start-to-done: NCH+1 cycles (9 for the defaults).
- rst asserted anywhere (including mid-RUN) → immediate return to reset values; the aborted operation never raises done.
- CHUNK=WIDTH: a single RUN cycle, latency 2.

## Configuration
- ADDER_SUB_EN defined: sub port exists; sub=1 at accept latches ~b and forces carry-in to 1 (ci ignored), giving a − b; co=1 means no borrow; ovf is signed overflow of the subtraction.
- ADDER_SUB_EN undefined: no sub port; the block is add-only; b and ci are used as given.

## Structure
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH/CHUNK constants.
- One sub-module, adder_chunk: combinational CHUNK-bit ripple-carry adder built from full-adder cells; outputs sum, carry-out and carry-into-MSB (the latter is used for ovf on the final chunk).
- Counter width: clog2(NCH), minimum 1.

## Test plan
- Defaults, a=0xFFFFFFFF, b=0x1, ci=0 → sum=0x00000000, co=1, ovf=0; done exactly 9 cycles after start; busy high for 8 cycles.
- a=0x7FFFFFFF, b=0x1, ci=0 → sum=0x80000000, co=0, ovf=1.
- start a=1, b=2, then start pulsed with a=0x10, b=0x10 during cycle 3 of RUN → second start ignored; sum=0x3; no second done.
- rst pulsed in RUN cycle 4 → busy=0, sum=0, no done; fresh start a=3, b=4, ci=1 → sum=0x8.
- ADDER_SUB_EN, a=5, b=7, sub=1 → sum=0xFFFFFFFE, co=0, ovf=0; a=7, b=5, sub=1 → sum=0x2, co=1.
- WIDTH=8, CHUNK=8, a=0x80, b=0x80, ci=0 → sum=0x00, co=1, ovf=1, done 2 cycles after start.
